// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among N_REQ requesters.
// Each FIFO entry is {last, id, payload} so the read side can demultiplex.
module async_fifo_wr_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BITS         = 32,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 16,
  localparam int unsigned ID_BITS     = $clog2(N_REQ),
  localparam int unsigned FIFO_BITS   = BITS + ID_BITS + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        p_req_valid,
  input  logic [N_REQ*BITS-1:0]   p_req_data,
  input  logic [N_REQ-1:0]        p_req_last,
  output logic [N_REQ-1:0]        p_req_ready,
  output logic                    p_fifo_write_en,
  output logic [FIFO_BITS-1:0]    p_fifo_write_data,
  input  logic                    p_fifo_write_full,
  output logic                    p_grant_valid,
  output logic [ID_BITS-1:0]      p_grant_id
);

  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);
  localparam int unsigned IC_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t             state;
  logic [ID_BITS-1:0] grant_id;
  logic [ID_BITS-1:0] rr_ptr;
  logic [BC_W-1:0]    beat_cnt;
  logic [IC_W-1:0]    idle_cnt;

  logic [BITS-1:0]    req_data [N_REQ];
  logic               pick_found;
  logic [ID_BITS-1:0] pick_id;
  logic [ID_BITS-1:0] cand_id;

  logic               valid_g;
  logic               last_g;
  logic [BITS-1:0]    data_g;
  logic               xfer;
  logic               release_grant;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_data[i] = p_req_data[i*BITS +: BITS];
    end
  end

  // Scan starts one past the last granted requester and wraps, so the
  // previous owner is considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand_id    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand_id = ID_BITS'((32'(rr_ptr) + i) % N_REQ);
      if (!pick_found && p_req_valid[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  always_comb begin
    valid_g = p_req_valid[grant_id];
    last_g  = p_req_last[grant_id];
    data_g  = req_data[grant_id];
    xfer    = (state == BURST) && valid_g && !p_fifo_write_full;
  end

  // Timeout counts only cycles where the owner has nothing to send; a stall
  // on full with data pending is not idleness.
  always_comb begin
    release_grant = 1'b0;
    if (state == BURST) begin
      if (xfer && (last_g || (beat_cnt + BC_W'(1) == BC_W'(MAX_BURST)))) begin
        release_grant = 1'b1;
      end else if (!valid_g && (idle_cnt + IC_W'(1) == IC_W'(IDLE_TIMEOUT))) begin
        release_grant = 1'b1;
      end
    end
  end

  always_comb begin
    p_req_ready       = '0;
    p_fifo_write_en   = 1'b0;
    p_fifo_write_data = '0;
    if (state == BURST && !p_fifo_write_full) begin
      p_req_ready[grant_id] = 1'b1;
    end
    if (xfer) begin
      p_fifo_write_en   = 1'b1;
      p_fifo_write_data = {last_g, grant_id, data_g};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_id      <= '0;
      rr_ptr        <= ID_BITS'(N_REQ - 1);
      beat_cnt      <= '0;
      idle_cnt      <= '0;
      p_grant_valid <= 1'b0;
      p_grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          idle_cnt <= '0;
          if (pick_found) begin
            state         <= BURST;
            grant_id      <= pick_id;
            p_grant_valid <= 1'b1;
            p_grant_id    <= pick_id;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + BC_W'(1);
            idle_cnt <= '0;
          end else if (!valid_g) begin
            idle_cnt <= idle_cnt + IC_W'(1);
          end
          if (release_grant) begin
            state         <= IDLE;
            rr_ptr        <= grant_id;
            p_grant_valid <= 1'b0;
            p_grant_id    <= '0;
          end
        end
        default: begin
          state         <= IDLE;
          p_grant_valid <= 1'b0;
          p_grant_id    <= '0;
        end
      endcase
    end
  end

endmodule
